// File: rtl/bcd_cnt999_down_pkg.sv
// Shared definitions for the three-digit BCD countdown timer.
// Holds the FSM state encoding, the BCD digit limits shared with the
// up-counter, and a helper that clamps a raw load nibble to a legal digit.
package bcd_cnt999_down_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    // Non-BCD nibbles (A-F) are stored as 9 so the registers never hold an
    // illegal digit.
    function automatic logic [3:0] bcd_sat(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_cnt999_down_digit_dn.sv
// Single BCD digit decrement with borrow, purely combinational.
// Ports:
//   digit      - current BCD digit (0..9)
//   borrow_in  - 1 = subtract one from this digit
//   next_digit - digit after the optional subtraction
//   borrow_out - 1 when this digit wrapped 0 -> 9
module bcd_digit_dn
    import bcd_cnt999_down_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       borrow_in,
    output logic [3:0] next_digit,
    output logic       borrow_out
);

    always_comb begin
        borrow_out = borrow_in && (digit == BCD_ZERO);
        if (!borrow_in) begin
            next_digit = digit;
        end else if (digit == BCD_ZERO) begin
            next_digit = BCD_MAX;
        end else begin
            next_digit = digit - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_cnt999_down.sv
// Three-digit BCD countdown timer (999..000) with loadable start value,
// one-cycle done pulse and optional auto-reload.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   load, ld_hun/ten/unit    - capture start value into count and reload regs
//   start, stop, tick        - run control and count enable
//   hun, ten, unit           - current count digits (registered)
//   busy                     - high while counting (RUN)
//   done                     - one-cycle pulse when 000 is reached
//   err                      - sticky: last load held a non-BCD digit
//
// state | meaning
// IDLE  | holding value, waiting for start
// RUN   | decrementing on each tick
// DONE  | count reached 000, single cycle
module bcd_cnt999_down
    import bcd_cnt999_down_pkg::*;
#(
    parameter int AUTO_RELOAD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] ld_hun,
    input  logic [3:0] ld_ten,
    input  logic [3:0] ld_unit,
    input  logic       start,
    input  logic       stop,
    input  logic       tick,
    output logic [3:0] hun,
    output logic [3:0] ten,
    output logic [3:0] unit,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_e     state_q, state_d;
    logic [3:0] hun_q, ten_q, unit_q;
    logic [3:0] hun_d, ten_d, unit_d;
    logic [3:0] rel_hun_q, rel_ten_q, rel_unit_q;
    logic [3:0] rel_hun_d, rel_ten_d, rel_unit_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [3:0] dec_hun, dec_ten, dec_unit;
    logic       b_unit, b_ten, b_hun;
    logic       cnt_zero, dec_zero, rel_zero, ld_bad;

    // Borrow chain always subtracts one at the units digit; the final borrow
    // out of the hundreds digit is therefore high exactly when the count is 000.
    bcd_digit_dn u_dig_unit (.digit(unit_q), .borrow_in(1'b1),   .next_digit(dec_unit), .borrow_out(b_unit));
    bcd_digit_dn u_dig_ten  (.digit(ten_q),  .borrow_in(b_unit), .next_digit(dec_ten),  .borrow_out(b_ten));
    bcd_digit_dn u_dig_hun  (.digit(hun_q),  .borrow_in(b_ten),  .next_digit(dec_hun),  .borrow_out(b_hun));

    assign cnt_zero = b_hun;
    assign dec_zero = (dec_hun == BCD_ZERO) && (dec_ten == BCD_ZERO) && (dec_unit == BCD_ZERO);
    assign rel_zero = (rel_hun_q == BCD_ZERO) && (rel_ten_q == BCD_ZERO) && (rel_unit_q == BCD_ZERO);
    assign ld_bad   = (ld_hun > BCD_MAX) || (ld_ten > BCD_MAX) || (ld_unit > BCD_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hun_q      <= BCD_ZERO;
            ten_q      <= BCD_ZERO;
            unit_q     <= BCD_ZERO;
            rel_hun_q  <= BCD_ZERO;
            rel_ten_q  <= BCD_ZERO;
            rel_unit_q <= BCD_ZERO;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hun_q      <= hun_d;
            ten_q      <= ten_d;
            unit_q     <= unit_d;
            rel_hun_q  <= rel_hun_d;
            rel_ten_q  <= rel_ten_d;
            rel_unit_q <= rel_unit_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Priority below rst: load > stop > start > tick.
    always_comb begin
        state_d    = state_q;
        hun_d      = hun_q;
        ten_d      = ten_q;
        unit_d     = unit_q;
        rel_hun_d  = rel_hun_q;
        rel_ten_d  = rel_ten_q;
        rel_unit_d = rel_unit_q;
        err_d      = err_q;
        if (load) begin
            hun_d      = bcd_sat(ld_hun);
            ten_d      = bcd_sat(ld_ten);
            unit_d     = bcd_sat(ld_unit);
            rel_hun_d  = bcd_sat(ld_hun);
            rel_ten_d  = bcd_sat(ld_ten);
            rel_unit_d = bcd_sat(ld_unit);
            err_d      = ld_bad;
            state_d    = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    // stop outranks start, so both together leave us idle.
                    if (!stop && start) begin
                        state_d = cnt_zero ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = IDLE;
                    end else if (tick) begin
                        hun_d  = dec_hun;
                        ten_d  = dec_ten;
                        unit_d = dec_unit;
                        if (dec_zero) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if ((AUTO_RELOAD != 0) && !rel_zero) begin
                        hun_d   = rel_hun_q;
                        ten_d   = rel_ten_q;
                        unit_d  = rel_unit_q;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Flags are decoded from the next state so they land in registers
    // alongside it.
    always_comb begin
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    assign hun  = hun_q;
    assign ten  = ten_q;
    assign unit = unit_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_cnt999_down.sv
module tb_bcd_cnt999_down;

    logic       clk;
    logic       rst, load, start, stop, tick;
    logic [3:0] ld_hun, ld_ten, ld_unit;
    logic [3:0] o_hun [2];
    logic [3:0] o_ten [2];
    logic [3:0] o_unit[2];
    logic       o_busy[2];
    logic       o_done[2];
    logic       o_err [2];

    int checks = 0;
    int errors = 0;

    // Behavioural model: count held as a plain integer 0..999.
    int m_cnt [2];
    int m_rel [2];
    bit m_run [2];
    bit m_done[2];
    bit m_err [2];
    bit mvalid = 0;

    bcd_cnt999_down #(.AUTO_RELOAD(0)) u_dut0 (
        .clk(clk), .rst(rst), .load(load), .ld_hun(ld_hun), .ld_ten(ld_ten), .ld_unit(ld_unit),
        .start(start), .stop(stop), .tick(tick),
        .hun(o_hun[0]), .ten(o_ten[0]), .unit(o_unit[0]),
        .busy(o_busy[0]), .done(o_done[0]), .err(o_err[0])
    );

    bcd_cnt999_down #(.AUTO_RELOAD(1)) u_dut1 (
        .clk(clk), .rst(rst), .load(load), .ld_hun(ld_hun), .ld_ten(ld_ten), .ld_unit(ld_unit),
        .start(start), .stop(stop), .tick(tick),
        .hun(o_hun[1]), .ten(o_ten[1]), .unit(o_unit[1]),
        .busy(o_busy[1]), .done(o_done[1]), .err(o_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat9(input int d);
        return (d > 9) ? 9 : d;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_cnt[k] = 0; m_rel[k] = 0; m_run[k] = 0; m_done[k] = 0; m_err[k] = 0;
            end else if (load) begin
                m_cnt[k]  = sat9(int'(ld_hun)) * 100 + sat9(int'(ld_ten)) * 10 + sat9(int'(ld_unit));
                m_rel[k]  = m_cnt[k];
                m_run[k]  = 0;
                m_done[k] = 0;
                m_err[k]  = (ld_hun > 9) || (ld_ten > 9) || (ld_unit > 9);
            end else if (m_done[k]) begin
                m_done[k] = 0;
                if (k == 1 && m_rel[k] != 0) begin
                    m_cnt[k] = m_rel[k];
                    m_run[k] = 1;
                end
            end else if (m_run[k]) begin
                if (stop) begin
                    m_run[k] = 0;
                end else if (tick) begin
                    m_cnt[k] = m_cnt[k] - 1;
                    if (m_cnt[k] == 0) begin
                        m_run[k]  = 0;
                        m_done[k] = 1;
                    end
                end
            end else if (!stop && start) begin
                if (m_cnt[k] != 0) m_run[k] = 1;
                else               m_done[k] = 1;
            end
        end
        mvalid = 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mvalid) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("model_hun[%0d]", k),  int'(o_hun[k]),  m_cnt[k] / 100);
                chk($sformatf("model_ten[%0d]", k),  int'(o_ten[k]),  (m_cnt[k] / 10) % 10);
                chk($sformatf("model_unit[%0d]", k), int'(o_unit[k]), m_cnt[k] % 10);
                chk($sformatf("model_busy[%0d]", k), int'(o_busy[k]), int'(m_run[k]));
                chk($sformatf("model_done[%0d]", k), int'(o_done[k]), int'(m_done[k]));
                chk($sformatf("model_err[%0d]", k),  int'(o_err[k]),  int'(m_err[k]));
            end
        end
    end

    function automatic int val(input int k);
        return int'(o_hun[k]) * 100 + int'(o_ten[k]) * 10 + int'(o_unit[k]);
    endfunction

    task automatic step(input bit r, input bit ld, input int lh, input int lt, input int lu,
                        input bit st, input bit sp, input bit tk);
        logic [3:0] h, t, u;
        h = lh[3:0]; t = lt[3:0]; u = lu[3:0];
        rst = r; load = ld; ld_hun = h; ld_ten = t; ld_unit = u;
        start = st; stop = sp; tick = tk;
        @(negedge clk);
    endtask

    initial begin
        rst = 1; load = 0; start = 0; stop = 0; tick = 0;
        ld_hun = 0; ld_ten = 0; ld_unit = 0;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_val", val(0), 0);
        chk("reset_busy", int'(o_busy[0]), 0);
        chk("reset_done", int'(o_done[0]), 0);
        chk("reset_err", int'(o_err[0]), 0);

        // 123 full countdown
        step(0, 1, 1, 2, 3, 0, 0, 0);
        chk("load123", val(0), 123);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk("start_busy", int'(o_busy[0]), 1);
        for (int i = 1; i <= 123; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 1);
            chk("cnt123", val(0), 123 - i);
            chk("cnt123_done", int'(o_done[0]), (i == 123) ? 1 : 0);
            chk("cnt123_busy", int'(o_busy[0]), (i == 123) ? 0 : 1);
        end
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("after_done_val", val(0), 0);
        chk("after_done_done", int'(o_done[0]), 0);

        // Double borrow
        step(0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("borrow_100", val(0), 99);
        step(0, 1, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("borrow_010", val(0), 9);

        // Stop / resume
        step(0, 1, 0, 0, 5, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        chk("stop_val", val(0), 3);
        chk("stop_busy", int'(o_busy[0]), 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("idle_tick_ignored", val(0), 3);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("resume_2", val(0), 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("resume_end", val(0), 0);
        chk("resume_done", int'(o_done[0]), 1);

        // Start at zero, invalid digit load
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1);
        chk("zero_start_done", int'(o_done[0]), 1);
        chk("zero_start_val", val(0), 0);
        step(0, 1, 0, 12, 2, 0, 0, 0);
        chk("bad_load_val", val(0), 92);
        chk("bad_load_err", int'(o_err[0]), 1);
        step(0, 1, 0, 0, 1, 0, 0, 0);
        chk("good_load_err", int'(o_err[0]), 0);

        // Auto-reload instance
        step(0, 1, 0, 0, 2, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("ar_1", val(1), 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("ar_0", val(1), 0);
        chk("ar_done", int'(o_done[1]), 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("ar_reload", val(1), 2);
        chk("ar_reload_busy", int'(o_busy[1]), 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("ar_done2", int'(o_done[1]), 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 7, 0, 0, 1);
        chk("ar_abort_val", val(1), 7);
        chk("ar_abort_busy", int'(o_busy[1]), 0);

        // Reset mid-count
        step(0, 1, 0, 5, 15, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("pre_rst_val", val(0), 57);
        chk("pre_rst_err", int'(o_err[0]), 1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_mid_val", val(0), 0);
        chk("rst_mid_busy", int'(o_busy[0]), 0);
        chk("rst_mid_err", int'(o_err[0]), 0);
        step(1, 1, 1, 2, 3, 0, 0, 0);
        chk("rst_over_load", val(0), 0);

        // Randomized phase, checked by the model process
        for (int n = 0; n < 3000; n++) begin
            int lh, lt, lu;
            lh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
            lt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
            lu = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
            step($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0, lh, lt, lu,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
        end

        step(0, 0, 0, 0, 0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
